frame_source_mux: RTL and testbench

//  Parametrised successor to the 3-way frame selector. Streams pixels from one of NUM_BUF frame

---
 rtl/frame_source_mux_pkg.sv | 14 +
 rtl/frame_pix_counter.sv | 33 +++
 rtl/frame_source_mux.sv | 132 +++++++++++++
 tb/tb_frame_source_mux.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_source_mux_pkg.sv
// Shared definitions for the frame source selector and its helpers.
// State encoding is kept as plain sized constants for legacy tooling.
// The blank source always takes the code just above the last buffer.
package frame_source_mux_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Code that selects the constant blank source for a given buffer count
  function automatic int blankCode(input int numBuf);
    return numBuf;
  endfunction

endpackage

// File: rtl/frame_pix_counter.sv
// Pixel position counter within a frame, with first/last-pixel flags.
// Latency: flags are combinational from the registered count.
// Backpressure: advances only on step; clear has priority and restarts at pixel 0.
module frame_pix_counter #(
  parameter int FRAME_PIX = 16,
  parameter int CNT_W     = $clog2(FRAME_PIX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             isFirst,
  output logic             isLast
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);

  assign isFirst = (cnt == '0);
  assign isLast  = (cnt == LAST_PIX);

  // Wrap explicitly at the last pixel so non-power-of-two frames work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= isLast ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_source_mux.sv
// Streams pixels from one of NUM_BUF buffers or a blank source, switching only at frame edges.
// Latency: 1 cycle from buffer pop to registered pix_data.
// Backpressure: output register holds on !pix_ready; no buffer pop happens while stalled.
module frame_source_mux
  import frame_source_mux_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                NUM_BUF   = 2,
  parameter int                FRAME_PIX = 16,
  parameter logic [DATA_W-1:0] BLANK_VAL = '0,
  localparam int               SEL_W     = $clog2(NUM_BUF + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [SEL_W-1:0]          sel_code,
  input  logic                      sel_load,
  input  logic [NUM_BUF*DATA_W-1:0] buf_data,
  input  logic [NUM_BUF-1:0]        buf_valid,
  output logic [NUM_BUF-1:0]        buf_ready,
  output logic [DATA_W-1:0]         pix_data,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      pix_sof,
  output logic                      pix_eof,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      sel_err,
  output logic                      underrun
);

  localparam logic [SEL_W-1:0] BLANK_SEL = SEL_W'(blankCode(NUM_BUF));
  localparam int               CNT_W     = $clog2(FRAME_PIX);

  logic [0:0]        state;
  logic [SEL_W-1:0]  activeSel;
  logic [SEL_W-1:0]  pendingSel;
  logic [CNT_W-1:0]  pixCnt;
  logic              cntFirst;
  logic              cntLast;
  logic              adv;
  logic              streamAdv;
  logic              startStream;
  logic              loadEof;
  logic              activeIsBuf;
  logic              selLegal;
  logic              srcValid;
  logic [DATA_W-1:0] srcData;

  assign adv         = !pix_valid || pix_ready;
  assign streamAdv   = (state == ST_STREAM) && adv;
  assign startStream = (state == ST_IDLE) && enable;
  assign loadEof     = streamAdv && cntLast;
  assign activeIsBuf = (activeSel != BLANK_SEL);
  assign selLegal    = (sel_code <= BLANK_SEL);
  assign active_sel  = activeSel;

  frame_pix_counter #(
    .FRAME_PIX (FRAME_PIX),
    .CNT_W     (CNT_W)
  ) uPixCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (startStream),
    .step    (streamAdv),
    .cnt     (pixCnt),
    .isFirst (cntFirst),
    .isLast  (cntLast)
  );

  // Pick the active buffer's pixel and pop it only when it is actually consumed
  always_comb begin
    srcData   = BLANK_VAL;
    srcValid  = 1'b0;
    buf_ready = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (activeSel == SEL_W'(i)) begin
        srcData      = buf_data[i*DATA_W +: DATA_W];
        srcValid     = buf_valid[i];
        buf_ready[i] = streamAdv && buf_valid[i];
      end
    end
  end

  // Frame sequencing and source selection; active source only moves at frame edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      activeSel  <= BLANK_SEL;
      pendingSel <= BLANK_SEL;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= sel_load && !selLegal;
      if (sel_load && selLegal) begin
        pendingSel <= sel_code;
      end
      if (startStream) begin
        state     <= ST_STREAM;
        activeSel <= pendingSel;
      end else if (loadEof) begin
        // A load coinciding with the last pixel still counts for the next frame
        activeSel <= (sel_load && selLegal) ? sel_code : pendingSel;
        if (!enable) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  // Output pixel register; underrun emits blank so frame timing never slips
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_data  <= BLANK_VAL;
      pix_sof   <= 1'b0;
      pix_eof   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= streamAdv && activeIsBuf && !srcValid;
      if (streamAdv) begin
        pix_valid <= 1'b1;
        pix_data  <= (activeIsBuf && srcValid) ? srcData : BLANK_VAL;
        pix_sof   <= cntFirst;
        pix_eof   <= cntLast;
      end else if (adv) begin
        pix_valid <= 1'b0;
        pix_sof   <= 1'b0;
        pix_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_source_mux.sv
// Scoreboard bench for frame_source_mux: expected pixels are queued as stimulus is issued,
// a forked monitor pops and compares each accepted output pixel.
// Buffer 0 is a ramp source (value = pops mod 16); buffer 1 is always valid to expose stray pops.
module tb_frame_source_mux;

  typedef struct {
    logic [7:0] dat;
    logic       sof;
    logic       eof;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  selCode;
  logic        selLoad;
  logic [15:0] bufData;
  logic [1:0]  bufValid;
  logic [1:0]  bufReady;
  logic [7:0]  pixData;
  logic        pixValid;
  logic        pixReady;
  logic        pixSof;
  logic        pixEof;
  logic [1:0]  activeSel;
  logic        selErr;
  logic        underrun;

  int   total = 0;
  int   bad = 0;
  int   monCnt = 0;
  int   underrunCnt = 0;
  int   selErrCnt = 0;
  int   base = 0;
  int   expVal0 = 0;
  int   popCnt0 = 0;
  int   popCnt1 = 0;
  int   snap;
  pix_t expQ[$];

  frame_source_mux #(
    .DATA_W    (8),
    .NUM_BUF   (2),
    .FRAME_PIX (16),
    .BLANK_VAL (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sel_code   (selCode),
    .sel_load   (selLoad),
    .buf_data   (bufData),
    .buf_valid  (bufValid),
    .buf_ready  (bufReady),
    .pix_data   (pixData),
    .pix_valid  (pixValid),
    .pix_ready  (pixReady),
    .pix_sof    (pixSof),
    .pix_eof    (pixEof),
    .active_sel (activeSel),
    .sel_err    (selErr),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Buffer models: each pop advances that buffer's ramp
  always @(posedge clk) begin
    if (bufReady[0]) popCnt0 <= popCnt0 + 1;
    if (bufReady[1]) popCnt1 <= popCnt1 + 1;
  end

  always_comb bufData = {8'hA0 | {4'h0, popCnt1[3:0]}, {4'h0, popCnt0[3:0]}};

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected frame: blank, or buffer-0 ramp with pixels uLo..uHi starved (blank, no pop)
  task automatic pushFrame(input bit blank, input int uLo, input int uHi);
    pix_t e;
    for (int p = 0; p < 16; p++) begin
      e.sof = (p == 0);
      e.eof = (p == 15);
      if (blank || (p >= uLo && p <= uHi)) begin
        e.dat = 8'h00;
      end else begin
        e.dat = 8'(expVal0 % 16);
        expVal0++;
      end
      expQ.push_back(e);
    end
  endtask

  function automatic int tgt(input int f, input int p);
    return base + 16 * f + p + 1;
  endfunction

  // Return #1 after the posedge that follows the monitor seeing pixel count n
  task automatic waitSeen(input int n);
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      k++;
      if (monCnt >= n || k >= 3000) break;
    end
    total++;
    if (monCnt < n) begin
      bad++;
      $display("FAIL wait_pixels: seen %0d, needed %0d", monCnt, n);
    end
    #1;
  endtask

  task automatic loadSel(input logic [1:0] code);
    selCode = code;
    selLoad = 1'b1;
    @(posedge clk);
    #1;
    selLoad = 1'b0;
    selCode = 2'd2;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_pix_valid"}, int'(pixValid), 0);
    check({tag, "_pix_sof"}, int'(pixSof), 0);
    check({tag, "_pix_eof"}, int'(pixEof), 0);
    check({tag, "_pix_data"}, int'(pixData), 0);
    check({tag, "_active_sel"}, int'(activeSel), 2);
    check({tag, "_buf_ready"}, int'(bufReady), 0);
    check({tag, "_sel_err"}, int'(selErr), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    selCode  = 2'd2;
    selLoad  = 1'b0;
    bufValid = 2'b11;
    pixReady = 1'b1;

    // Monitor: compare every accepted pixel against the queue head
    fork
      forever begin
        pix_t e;
        @(negedge clk);
        if (rst_n && pixValid && pixReady) begin
          total++;
          if (expQ.size() == 0) begin
            bad++;
            $display("FAIL pix_unexpected[%0d]: got dat=%h sof=%b eof=%b, expected no pixel",
                     monCnt, pixData, pixSof, pixEof);
          end else begin
            e = expQ.pop_front();
            if (pixData !== e.dat || pixSof !== e.sof || pixEof !== e.eof) begin
              bad++;
              $display("FAIL pix[%0d]: got dat=%h sof=%b eof=%b, expected dat=%h sof=%b eof=%b",
                       monCnt, pixData, pixSof, pixEof, e.dat, e.sof, e.eof);
            end
          end
          monCnt++;
        end
        if (rst_n && underrun) underrunCnt++;
        if (rst_n && selErr) selErrCnt++;
      end
    join_none

    #12;
    checkResetOutputs("reset");

    // Test 1: blank frames F0..F2
    pushFrame(1'b1, 99, -1);
    pushFrame(1'b1, 99, -1);
    pushFrame(1'b1, 99, -1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 enable = 1'b1;

    // Test 2: select buffer 0 during F2; F3 onwards is the ramp
    pushFrame(1'b0, 99, -1);
    pushFrame(1'b0, 99, -1);
    waitSeen(tgt(1, 8));
    check("active_blank_midframe", int'(activeSel), 2);
    waitSeen(tgt(2, 3));
    loadSel(2'd0);
    waitSeen(tgt(2, 15));
    snap = popCnt0;
    waitSeen(tgt(3, 15));
    check("buf0_pops_per_frame", popCnt0 - snap, 16);
    check("active_buf0", int'(activeSel), 0);

    // Test 3: sel=1 then sel=0 within F4; last write wins, F5 stays on buffer 0
    waitSeen(tgt(4, 3));
    loadSel(2'd1);
    waitSeen(tgt(4, 7));
    loadSel(2'd0);
    pushFrame(1'b0, 99, -1);
    waitSeen(tgt(5, 1));
    check("no_buf1_pops", popCnt1, 0);

    // Test 4: illegal code pulses sel_err for one cycle, selection unchanged
    waitSeen(tgt(5, 2));
    selCode = 2'd3;
    selLoad = 1'b1;
    @(negedge clk);
    check("sel_err_before", int'(selErr), 0);
    @(posedge clk);
    #1;
    selLoad = 1'b0;
    selCode = 2'd2;
    @(negedge clk);
    check("sel_err_pulse", int'(selErr), 1);
    @(negedge clk);
    check("sel_err_after", int'(selErr), 0);
    check("active_after_illegal", int'(activeSel), 0);

    // Test 5: starve buffer 0 for pixels 4..6 of F6
    pushFrame(1'b0, 4, 6);
    waitSeen(tgt(6, 2));
    bufValid = 2'b10;
    waitSeen(tgt(6, 5));
    bufValid = 2'b11;
    pushFrame(1'b0, 99, -1);
    waitSeen(tgt(6, 15));
    check("underrun_pulses", underrunCnt, 3);

    // Test 6: 3-cycle stall mid-F7, then enable drop at pixel 8
    waitSeen(tgt(7, 3));
    pixReady = 1'b0;
    snap = popCnt0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_pix_data", int'(pixData), int'(expQ[0].dat));
      check("stall_pix_sof", int'(pixSof), int'(expQ[0].sof));
      check("stall_pops", popCnt0, snap);
    end
    @(posedge clk);
    #1 pixReady = 1'b1;
    waitSeen(tgt(7, 6));
    enable = 1'b0;
    waitSeen(tgt(7, 15));
    repeat (3) @(negedge clk);
    check("idle_pix_valid", int'(pixValid), 0);
    check("idle_queue_empty", expQ.size(), 0);
    snap = popCnt0;
    repeat (5) @(negedge clk);
    check("idle_no_pops", popCnt0, snap);

    // Reset mid-frame: outputs go to reset values without waiting for a clock
    pushFrame(1'b0, 99, -1);
    @(posedge clk);
    #1 enable = 1'b1;
    waitSeen(tgt(8, 5));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    expQ.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = monCnt - 16 * 9;

    // After reset the pending source is blank again
    pushFrame(1'b1, 99, -1);
    waitSeen(tgt(9, 6));
    enable = 1'b0;
    waitSeen(tgt(9, 15));
    repeat (3) @(negedge clk);
    check("final_pix_valid", int'(pixValid), 0);
    check("final_queue_empty", expQ.size(), 0);
    check("final_buf1_pops", popCnt1, 0);
    check("final_sel_err_count", selErrCnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
